// File: rtl/gnn_layer_seq_if.sv
// Handshake and data bundle for the time-multiplexed GNN layer engine.
// The producer/consumer side uses the master modport; the engine uses slave.
interface gnn_layer_seq_if #(
    parameter int N_NODES = 4,
    parameter int N_FEAT  = 4,
    parameter int N_OUT   = 2,
    parameter int DW      = 5
);
    localparam int AGW = DW + $clog2(N_NODES + 1);
    localparam int OW  = AGW + DW + $clog2(N_FEAT + 1);

    logic                            in_valid;
    logic                            in_ready;
    logic [N_NODES*N_FEAT*DW-1:0]    x_in;
    logic [N_NODES*N_NODES-1:0]      adj_in;
    logic [N_FEAT*N_OUT*DW-1:0]      w_in;
    logic                            relu_en;
    logic                            out_valid;
    logic                            out_ready;
    logic [N_NODES*N_OUT*OW-1:0]     y_out;
    logic                            busy;

    modport master (
        output in_valid, x_in, adj_in, w_in, relu_en, out_ready,
        input  in_ready, out_valid, y_out, busy
    );

    modport slave (
        input  in_valid, x_in, adj_in, w_in, relu_en, out_ready,
        output in_ready, out_valid, y_out, busy
    );
endinterface

// File: rtl/gnn_layer_seq.sv
// Single-layer GNN engine: captures a graph bundle, aggregates neighbour
// features one node per cycle, then evaluates the shared linear layer one
// (node, output) pair per cycle and holds the results under out_valid/out_ready.
module gnn_layer_seq #(
    parameter int N_NODES = 4,
    parameter int N_FEAT  = 4,
    parameter int N_OUT   = 2,
    parameter int DW      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    gnn_layer_seq_if.slave  bus
);
    localparam int AGW = DW + $clog2(N_NODES + 1);
    localparam int OW  = AGW + DW + $clog2(N_FEAT + 1);
    localparam int NW  = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int XW  = N_NODES * N_FEAT * DW;
    localparam int WW  = N_FEAT * N_OUT * DW;
    localparam int AW  = N_NODES * N_NODES;
    localparam int YW  = N_NODES * N_OUT * OW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AGG  = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Control state
    state_t          state_q;
    logic [NW-1:0]   node_q;
    logic [OCW-1:0]  outi_q;
    logic            out_valid_q;

    // Captured bundle, aggregates and results
    logic [XW-1:0]             x_q;
    logic [AW-1:0]             adj_q;
    logic [WW-1:0]             w_q;
    logic                      relu_q;
    logic signed [AGW-1:0]     agg_q [N_NODES][N_FEAT];
    logic [YW-1:0]             y_q;

    // Combinational datapath results for the current step
    logic [N_NODES-1:0]        adj_row_d;
    logic signed [AGW-1:0]     agg_row_d [N_FEAT];
    logic signed [AGW-1:0]     agg_sel_d [N_FEAT];
    logic [DW-1:0]             w_col_d   [N_FEAT];
    logic signed [OW-1:0]      mac_d;
    logic signed [OW-1:0]      y_pair_d;

    logic accept;
    logic last_node;
    logic last_out;

    // Sign-extend a raw DW-bit feature to aggregate width.
    function automatic logic signed [AGW-1:0] sext_feat(input logic [DW-1:0] v);
        return {{(AGW-DW){v[DW-1]}}, v};
    endfunction

    // One aggregate*weight product at full output precision.
    function automatic logic signed [OW-1:0] mul_term(input logic signed [AGW-1:0] a,
                                                      input logic [DW-1:0] w);
        logic signed [OW-1:0] ae;
        logic signed [OW-1:0] we;
        ae = {{(OW-AGW){a[AGW-1]}}, a};
        we = {{(OW-DW){w[DW-1]}}, w};
        return ae * we;
    endfunction

    // Optional ReLU clamp; the output width never overflows so no saturation.
    function automatic logic signed [OW-1:0] apply_relu(input logic signed [OW-1:0] v,
                                                        input logic en);
        return (en && v[OW-1]) ? '0 : v;
    endfunction

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign last_node = (node_q == NW'(N_NODES - 1));
    assign last_out  = (outi_q == OCW'(N_OUT - 1));

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;

    // Aggregate of the current node's neighbours plus operand selection for the MAC pair.
    always_comb begin
        adj_row_d = '0;
        for (int i = 0; i < N_NODES; i++) begin
            if (node_q == NW'(i)) adj_row_d = adj_q[i*N_NODES +: N_NODES];
        end
        for (int f = 0; f < N_FEAT; f++) begin
            agg_row_d[f] = '0;
            agg_sel_d[f] = '0;
            w_col_d[f]   = '0;
        end
        for (int f = 0; f < N_FEAT; f++) begin
            for (int j = 0; j < N_NODES; j++) begin
                if (adj_row_d[j]) agg_row_d[f] = agg_row_d[f] + sext_feat(x_q[(j*N_FEAT+f)*DW +: DW]);
            end
            for (int i = 0; i < N_NODES; i++) begin
                if (node_q == NW'(i)) agg_sel_d[f] = agg_q[i][f];
            end
            for (int o = 0; o < N_OUT; o++) begin
                if (outi_q == OCW'(o)) w_col_d[f] = w_q[(f*N_OUT+o)*DW +: DW];
            end
        end
        mac_d = '0;
        for (int f = 0; f < N_FEAT; f++) begin
            mac_d = mac_d + mul_term(agg_sel_d[f], w_col_d[f]);
        end
        y_pair_d = apply_relu(mac_d, relu_q);
    end

    // Sequencer: IDLE -> AGG (one node/cycle) -> MAC (one pair/cycle) -> DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            node_q      <= '0;
            outi_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= AGG;
                        node_q  <= '0;
                        outi_q  <= '0;
                    end
                end
                AGG: begin
                    if (last_node) begin
                        state_q <= MAC;
                        node_q  <= '0;
                        outi_q  <= '0;
                    end else begin
                        node_q <= node_q + NW'(1);
                    end
                end
                MAC: begin
                    if (last_out) begin
                        outi_q <= '0;
                        if (last_node) begin
                            state_q     <= DONE;
                            node_q      <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            node_q <= node_q + NW'(1);
                        end
                    end else begin
                        outi_q <= outi_q + OCW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Capture on accept, write one aggregate row in AGG and one result in MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            adj_q  <= '0;
            w_q    <= '0;
            relu_q <= 1'b0;
            y_q    <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                for (int f = 0; f < N_FEAT; f++) begin
                    agg_q[i][f] <= '0;
                end
            end
        end else begin
            if (accept) begin
                x_q    <= bus.x_in;
                adj_q  <= bus.adj_in;
                w_q    <= bus.w_in;
                relu_q <= bus.relu_en;
                y_q    <= '0;
            end
            if (state_q == AGG) begin
                for (int i = 0; i < N_NODES; i++) begin
                    if (node_q == NW'(i)) begin
                        for (int f = 0; f < N_FEAT; f++) begin
                            agg_q[i][f] <= agg_row_d[f];
                        end
                    end
                end
            end
            if (state_q == MAC) begin
                for (int n = 0; n < N_NODES; n++) begin
                    for (int o = 0; o < N_OUT; o++) begin
                        if (node_q == NW'(n) && outi_q == OCW'(o)) begin
                            y_q[(n*N_OUT+o)*OW +: OW] <= y_pair_d;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gnn_layer_seq.sv
// Directed bench for gnn_layer_seq at default parameters.
module tb_gnn_layer_seq;
    localparam int N_NODES = 4;
    localparam int N_FEAT  = 4;
    localparam int N_OUT   = 2;
    localparam int DW      = 5;
    localparam int AGW     = DW + $clog2(N_NODES + 1);
    localparam int OW      = AGW + DW + $clog2(N_FEAT + 1);
    localparam int XW      = N_NODES * N_FEAT * DW;
    localparam int WW      = N_FEAT * N_OUT * DW;
    localparam int AW      = N_NODES * N_NODES;
    localparam int YW      = N_NODES * N_OUT * OW;
    localparam logic [AW-1:0] ADJ_LEGACY = 16'b0111_1101_1011_0111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gnn_layer_seq_if #(.N_NODES(N_NODES), .N_FEAT(N_FEAT), .N_OUT(N_OUT), .DW(DW)) bus ();

    gnn_layer_seq #(.N_NODES(N_NODES), .N_FEAT(N_FEAT), .N_OUT(N_OUT), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [XW-1:0] x_fill(input int v);
        logic [XW-1:0] r;
        r = '0;
        for (int k = 0; k < N_NODES * N_FEAT; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [WW-1:0] w_fill(input int v);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < N_FEAT * N_OUT; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [YW-1:0] y_fill(input int v);
        logic [YW-1:0] r;
        r = '0;
        for (int k = 0; k < N_NODES * N_OUT; k++) r[k*OW +: OW] = OW'(v);
        return r;
    endfunction

    function automatic logic signed [OW-1:0] get_y(input int n, input int o);
        return bus.y_out[(n*N_OUT+o)*OW +: OW];
    endfunction

    // Present one bundle, wait for out_valid; lat = edges after accept (-1 on timeout).
    task automatic run_job(input logic [AW-1:0] adj, input logic [XW-1:0] x,
                           input logic [WW-1:0] w, input logic relu,
                           output int lat, output bit busy_ok);
        @(negedge clk);
        bus.adj_in   = adj;
        bus.x_in     = x;
        bus.w_in     = w;
        bus.relu_en  = relu;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.out_valid) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.adj_in    = '0;
        bus.w_in      = '0;
        bus.relu_en   = 1'b0;
        #2;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++;
        if (bus.y_out !== '0) $display("FAIL reset_y_out got %h want 0", bus.y_out); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_legacy();
        int lat;
        bit bok;
        run_job(ADJ_LEGACY, x_fill(1), w_fill(1), 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL legacy_latency got %0d want 12", lat); else pass_cnt++;
        total_cnt++;
        if (bok !== 1'b1) $display("FAIL legacy_busy got %b want 1", bok); else pass_cnt++;
        for (int n = 0; n < N_NODES; n++)
            for (int o = 0; o < N_OUT; o++) begin
                total_cnt++;
                if (get_y(n, o) !== OW'(12))
                    $display("FAIL legacy_y[%0d][%0d] got %0d want 12", n, o, get_y(n, o));
                else pass_cnt++;
            end
        release_out();
    endtask

    task automatic test_extreme();
        int lat;
        bit bok;
        run_job('1, x_fill(-16), w_fill(-16), 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL extreme_latency got %0d want 12", lat); else pass_cnt++;
        for (int n = 0; n < N_NODES; n++)
            for (int o = 0; o < N_OUT; o++) begin
                total_cnt++;
                if (get_y(n, o) !== OW'(4096))
                    $display("FAIL extreme_y[%0d][%0d] got %0d want 4096", n, o, get_y(n, o));
                else pass_cnt++;
            end
        release_out();
    endtask

    task automatic test_relu();
        int lat;
        bit bok;
        for (int r = 0; r < 2; r++) begin
            run_job(ADJ_LEGACY, x_fill(1), w_fill(-1), r[0], lat, bok);
            total_cnt++;
            if (lat !== 12) $display("FAIL relu%0d_latency got %0d want 12", r, lat); else pass_cnt++;
            for (int n = 0; n < N_NODES; n++)
                for (int o = 0; o < N_OUT; o++) begin
                    total_cnt++;
                    if (get_y(n, o) !== OW'((r == 0) ? -12 : 0))
                        $display("FAIL relu%0d_y[%0d][%0d] got %0d want %0d", r, n, o, get_y(n, o), (r == 0) ? -12 : 0);
                    else pass_cnt++;
                end
            release_out();
        end
    endtask

    // Distinct values per node/feature/output: rows {0},{1,2},{3},{} with x[j][f]=j-f.
    task automatic test_mixed();
        int lat;
        bit bok;
        int want;
        int exp_y [N_NODES][N_OUT];
        logic [XW-1:0] x;
        logic [WW-1:0] w;
        exp_y = '{'{-20, -6}, '{-10, -6}, '{10, 0}, '{0, 0}};
        x = '0;
        w = '0;
        for (int j = 0; j < N_NODES; j++)
            for (int f = 0; f < N_FEAT; f++) x[(j*N_FEAT+f)*DW +: DW] = DW'(j - f);
        for (int f = 0; f < N_FEAT; f++) begin
            w[(f*N_OUT+0)*DW +: DW] = DW'(f + 1);
            w[(f*N_OUT+1)*DW +: DW] = DW'((f % 2 == 0) ? -1 : 2);
        end
        for (int r = 0; r < 2; r++) begin
            run_job(16'h0861, x, w, r[0], lat, bok);
            total_cnt++;
            if (lat !== 12) $display("FAIL mixed%0d_latency got %0d want 12", r, lat); else pass_cnt++;
            for (int n = 0; n < N_NODES; n++)
                for (int o = 0; o < N_OUT; o++) begin
                    want = (r == 1 && exp_y[n][o] < 0) ? 0 : exp_y[n][o];
                    total_cnt++;
                    if (get_y(n, o) !== OW'(want))
                        $display("FAIL mixed%0d_y[%0d][%0d] got %0d want %0d", r, n, o, get_y(n, o), want);
                    else pass_cnt++;
                end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit bok;
        run_job(ADJ_LEGACY, x_fill(1), w_fill(1), 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL bp_latency got %0d want 12", lat); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = c[0] ? 1'b0 : 1'b1;
            bus.x_in     = {$urandom, $urandom, $urandom};
            @(negedge clk);
            total_cnt++;
            if (bus.y_out !== y_fill(12)) $display("FAIL bp_hold_y cycle %0d got %h want %h", c, bus.y_out, y_fill(12)); else pass_cnt++;
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", c, bus.in_ready); else pass_cnt++;
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid cycle %0d got %b want 1", c, bus.out_valid); else pass_cnt++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        // Second run straight away with new data: agg=6, y=4*6*1=24.
        run_job(ADJ_LEGACY, x_fill(2), w_fill(1), 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL b2b_latency got %0d want 12", lat); else pass_cnt++;
        for (int n = 0; n < N_NODES; n++)
            for (int o = 0; o < N_OUT; o++) begin
                total_cnt++;
                if (get_y(n, o) !== OW'(24))
                    $display("FAIL b2b_y[%0d][%0d] got %0d want 24", n, o, get_y(n, o));
                else pass_cnt++;
            end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        @(negedge clk);
        bus.adj_in   = ADJ_LEGACY;
        bus.x_in     = x_fill(1);
        bus.w_in     = w_fill(1);
        bus.relu_en  = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++;
        if (bus.y_out !== '0) $display("FAIL midrst_y_out got %h want 0", bus.y_out); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        // Fresh run: x=-1, w=1 gives agg=-3 and y=-12.
        run_job(ADJ_LEGACY, x_fill(-1), w_fill(1), 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL midrst_run_latency got %0d want 12", lat); else pass_cnt++;
        for (int n = 0; n < N_NODES; n++)
            for (int o = 0; o < N_OUT; o++) begin
                total_cnt++;
                if (get_y(n, o) !== OW'(-12))
                    $display("FAIL midrst_run_y[%0d][%0d] got %0d want -12", n, o, get_y(n, o));
                else pass_cnt++;
            end
        release_out();
    endtask

    task automatic test_empty();
        int lat;
        bit bok;
        logic [XW-1:0] x;
        logic [WW-1:0] w;
        for (int k = 0; k < N_NODES * N_FEAT; k++) x[k*DW +: DW] = DW'($urandom);
        for (int k = 0; k < N_FEAT * N_OUT; k++) w[k*DW +: DW] = DW'($urandom);
        run_job('0, x, w, 1'b0, lat, bok);
        total_cnt++;
        if (lat !== 12) $display("FAIL empty_latency got %0d want 12", lat); else pass_cnt++;
        total_cnt++;
        if (bus.y_out !== '0) $display("FAIL empty_y got %h want 0", bus.y_out); else pass_cnt++;
        release_out();
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_extreme();
        test_relu();
        test_mixed();
        test_backpressure();
        test_reset_mid();
        test_empty();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
